// File: rtl/tapa_ctrl_pkg.sv
// Shared controller types: FSM state encoding,
// cycle counter width and a saturating increment.
package tapa_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int CYCLE_CNT_W = 32;

  localparam logic [CYCLE_CNT_W-1:0] CNT_ONE =
    {{(CYCLE_CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CYCLE_CNT_W-1:0] sat_inc(
    input logic [CYCLE_CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_ONE;
  endfunction

endpackage

// File: rtl/slot_ctrl_tracker.sv
// Per-slot held start bit and sticky done bit.
// Ports: arm (set start, clear done), clear (drop both), ready/done pulses.
module slot_ctrl_tracker (
  input  logic ap_clk,
  input  logic ap_rst_n,
  input  logic arm,
  input  logic clear,
  input  logic ready,
  input  logic done,
  output logic start,
  output logic done_bit
);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      start    <= 1'b0;
      done_bit <= 1'b0;
    end else if (arm) begin
      start    <= 1'b1;
      done_bit <= 1'b0;
    end else if (clear) begin
      start    <= 1'b0;
      done_bit <= 1'b0;
    end else begin
      if (ready) start    <= 1'b0;
      if (done)  done_bit <= 1'b1;
    end
  end

endmodule

// File: rtl/top_ctrl_fanout.sv
// ap_ctrl_hs fan-out controller: host start -> held slot starts,
// slot done pulses -> single host done/ready. Scalars registered per run.
// Ports: ap_* host handshake, scalar_in/out, slot_ap_* per slot, run_cycles.
// Optional macro TOP_CTRL_CYCLE_CNT_EN: run_cycles reports last run length.
module top_ctrl_fanout
  import tapa_ctrl_pkg::*;
#(
  parameter int NUM_SLOTS   = 4,
  parameter int NUM_SCALARS = 2,
  parameter int SCALAR_W    = 64
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst_n,
  input  logic                            ap_start,
  output logic                            ap_ready,
  output logic                            ap_done,
  output logic                            ap_idle,
  input  logic [NUM_SCALARS*SCALAR_W-1:0] scalar_in,
  output logic [NUM_SCALARS*SCALAR_W-1:0] scalar_out,
  output logic [NUM_SLOTS-1:0]            slot_ap_start,
  input  logic [NUM_SLOTS-1:0]            slot_ap_ready,
  input  logic [NUM_SLOTS-1:0]            slot_ap_done,
  input  logic [NUM_SLOTS-1:0]            slot_ap_idle,
  output logic [CYCLE_CNT_W-1:0]          run_cycles
);

  state_e state_q, state_d;
  logic arm, clear, in_run, all_done;
  logic [NUM_SLOTS-1:0] done_bits;

  // Slot idle is status only.
  logic unused_idle;
  assign unused_idle = ^slot_ap_idle;

  assign in_run = (state_q == RUN);
  // Includes pulses landing this cycle so the exit edge is not delayed.
  assign all_done = &(done_bits | slot_ap_done);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ap_idle = 1'b0;
    ap_done = 1'b0;
    arm     = 1'b0;
    clear   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (all_done) state_d = DONE;
      end
      DONE: begin
        ap_done = 1'b1;
        clear   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        ap_idle = 1'b1;
        state_d = IDLE;
        if (ap_start) begin
          arm     = 1'b1;
          state_d = RUN;
        end
      end
    endcase
  end

  assign ap_ready = ap_done;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)  scalar_out <= '0;
    else if (arm)   scalar_out <= scalar_in;
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    slot_ctrl_tracker u_trk (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .arm      (arm),
      .clear    (clear),
      .ready    (slot_ap_ready[i] & in_run),
      .done     (slot_ap_done[i] & in_run),
      .start    (slot_ap_start[i]),
      .done_bit (done_bits[i])
    );
  end

`ifdef TOP_CTRL_CYCLE_CNT_EN
  logic [CYCLE_CNT_W-1:0] cnt_q, run_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt_q <= '0;
      run_q <= '0;
    end else begin
      if (arm)         cnt_q <= '0;
      else if (in_run) cnt_q <= sat_inc(cnt_q);
      // Reported length spans the acceptance cycle through the
      // final RUN cycle, hence two steps past the running count.
      if (in_run && all_done)
        run_q <= sat_inc(sat_inc(cnt_q));
    end
  end

  assign run_cycles = run_q;
`else
  assign run_cycles = '0;
`endif

endmodule

// File: tb/tb_top_ctrl_fanout.sv
// Randomized self-checking bench for top_ctrl_fanout.
// Expected behaviour derived from per-slot ready/done times.
module tb_top_ctrl_fanout;

  localparam int NS = 4;
  localparam int NK = 2;
  localparam int SW = 64;
`ifdef TOP_CTRL_CYCLE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic              ap_clk = 1'b0;
  logic              ap_rst_n = 1'b1;
  logic              ap_start = 1'b0;
  logic              ap_ready, ap_done, ap_idle;
  logic [NK*SW-1:0]  scalar_in = '0;
  logic [NK*SW-1:0]  scalar_out;
  logic [NS-1:0]     slot_ap_start;
  logic [NS-1:0]     slot_ap_ready = '0;
  logic [NS-1:0]     slot_ap_done = '0;
  logic [NS-1:0]     slot_ap_idle = '0;
  logic [31:0]       run_cycles;

  int errors = 0;
  int checks = 0;
  logic [31:0]      exp_rc = '0;
  logic [NK*SW-1:0] last_sc = '0;

  top_ctrl_fanout #(
    .NUM_SLOTS(NS), .NUM_SCALARS(NK), .SCALAR_W(SW)
  ) dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .ap_start      (ap_start),
    .ap_ready      (ap_ready),
    .ap_done       (ap_done),
    .ap_idle       (ap_idle),
    .scalar_in     (scalar_in),
    .scalar_out    (scalar_out),
    .slot_ap_start (slot_ap_start),
    .slot_ap_ready (slot_ap_ready),
    .slot_ap_done  (slot_ap_done),
    .slot_ap_idle  (slot_ap_idle),
    .run_cycles    (run_cycles)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  function automatic logic [NK*SW-1:0] rnd_sc();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_run(input int r[NS], input int d[NS],
                        input logic [NK*SW-1:0] sc,
                        input bit hold, input bit dup,
                        input string tag);
    int D;
    logic [NS-1:0] es, rdy, dn;
    D = 0;
    for (int i = 0; i < NS; i++) if (d[i] > D) D = d[i];
    ap_start = 1'b1;
    scalar_in = sc;
    slot_ap_ready = '0;
    slot_ap_done = '0;
    checks++;
    if (ap_idle !== 1'b1) begin
      errors++;
      $display("FAIL %s accept ap_idle got=%b exp=1", tag, ap_idle);
    end
    checks++;
    if (run_cycles !== exp_rc) begin
      errors++;
      $display("FAIL %s run_cycles got=%0d exp=%0d",
               tag, run_cycles, exp_rc);
    end
    tick();
    for (int k = 1; k <= D + 1; k++) begin
      ap_start = hold ? 1'b1 : 1'($urandom_range(0, 1));
      scalar_in = rnd_sc();
      slot_ap_idle = 4'($urandom);
      for (int i = 0; i < NS; i++) begin
        es[i]  = (k <= r[i]);
        rdy[i] = (k == r[i]);
        dn[i]  = (k == d[i]) || (dup && k > d[i] && k < D);
      end
      slot_ap_ready = rdy;
      slot_ap_done = dn;
      checks++;
      if (slot_ap_start !== es) begin
        errors++;
        $display("FAIL %s k=%0d slot_ap_start got=%b exp=%b",
                 tag, k, slot_ap_start, es);
      end
      checks++;
      if (ap_done !== (k == D + 1)) begin
        errors++;
        $display("FAIL %s k=%0d ap_done got=%b exp=%b",
                 tag, k, ap_done, (k == D + 1));
      end
      checks++;
      if (ap_ready !== (k == D + 1)) begin
        errors++;
        $display("FAIL %s k=%0d ap_ready got=%b exp=%b",
                 tag, k, ap_ready, (k == D + 1));
      end
      checks++;
      if (ap_idle !== 1'b0) begin
        errors++;
        $display("FAIL %s k=%0d ap_idle got=%b exp=0", tag, k, ap_idle);
      end
      checks++;
      if (scalar_out !== sc) begin
        errors++;
        $display("FAIL %s k=%0d scalar_out got=%h exp=%h",
                 tag, k, scalar_out, sc);
      end
      tick();
    end
    slot_ap_ready = '0;
    slot_ap_done = '0;
    if (!hold) ap_start = 1'b0;
    exp_rc = CNT_EN ? 32'(D + 1) : 32'd0;
    last_sc = sc;
  endtask

  task automatic idle_check(input int n, input string tag);
    ap_start = 1'b0;
    for (int k = 0; k < n; k++) begin
      scalar_in = rnd_sc();
      checks++;
      if (ap_idle !== 1'b1) begin
        errors++;
        $display("FAIL %s ap_idle got=%b exp=1", tag, ap_idle);
      end
      checks++;
      if (ap_done !== 1'b0 || ap_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s done/ready got=%b%b exp=00",
                 tag, ap_done, ap_ready);
      end
      checks++;
      if (slot_ap_start !== '0) begin
        errors++;
        $display("FAIL %s slot_ap_start got=%b exp=0000",
                 tag, slot_ap_start);
      end
      checks++;
      if (run_cycles !== exp_rc) begin
        errors++;
        $display("FAIL %s run_cycles got=%0d exp=%0d",
                 tag, run_cycles, exp_rc);
      end
      checks++;
      if (scalar_out !== last_sc) begin
        errors++;
        $display("FAIL %s scalar_out got=%h exp=%h",
                 tag, scalar_out, last_sc);
      end
      tick();
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    checks++;
    if (ap_idle !== 1'b1 || ap_done !== 1'b0 || ap_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s idle/done/ready got=%b%b%b exp=100",
               tag, ap_idle, ap_done, ap_ready);
    end
    checks++;
    if (slot_ap_start !== '0) begin
      errors++;
      $display("FAIL %s slot_ap_start got=%b exp=0000",
               tag, slot_ap_start);
    end
    checks++;
    if (scalar_out !== '0) begin
      errors++;
      $display("FAIL %s scalar_out got=%h exp=0", tag, scalar_out);
    end
    checks++;
    if (run_cycles !== 32'd0) begin
      errors++;
      $display("FAIL %s run_cycles got=%0d exp=0", tag, run_cycles);
    end
  endtask

  task automatic test_reset();
    scalar_in = rnd_sc();
    #2 ap_rst_n = 1'b0;
    #1;
    chk_reset_vals("reset_async");
    tick();
    tick();
    chk_reset_vals("reset_held");
    ap_rst_n = 1'b1;
    tick();
    exp_rc = '0;
    last_sc = '0;
    idle_check(2, "reset_idle");
  endtask

  task automatic test_directed();
    int r[NS] = '{3, 5, 9, 4};
    do_run(r, r, {64'd5, 64'd7}, 1'b0, 1'b0, "directed");
    idle_check(2, "directed_idle");
    if (CNT_EN) begin
      checks++;
      if (run_cycles !== 32'd10) begin
        errors++;
        $display("FAIL cnt_directed run_cycles got=%0d exp=10",
                 run_cycles);
      end
    end else begin
      checks++;
      if (run_cycles !== 32'd0) begin
        errors++;
        $display("FAIL cnt_off run_cycles got=%0d exp=0", run_cycles);
      end
    end
  endtask

  task automatic test_duplicate_done();
    int r[NS] = '{1, 2, 3, 2};
    int d[NS] = '{2, 6, 7, 5};
    do_run(r, d, rnd_sc(), 1'b0, 1'b1, "dup_done");
    idle_check(1, "dup_idle");
  endtask

  task automatic test_min_run();
    int r[NS] = '{1, 1, 1, 1};
    do_run(r, r, rnd_sc(), 1'b0, 1'b0, "min_run");
    idle_check(1, "min_idle");
  endtask

  task automatic test_back_to_back();
    int r[NS] = '{2, 2, 2, 2};
    for (int n = 0; n < 4; n++)
      do_run(r, r, rnd_sc(), (n < 3), 1'b0, "b2b");
    idle_check(2, "b2b_idle");
  endtask

  task automatic test_random();
    int r[NS];
    int d[NS];
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < NS; i++) begin
        r[i] = $urandom_range(1, 8);
        d[i] = r[i] + $urandom_range(0, 4);
      end
      do_run(r, d, rnd_sc(), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), "random");
      if (ap_start == 1'b0) idle_check($urandom_range(1, 3), "rnd_idle");
    end
    idle_check(1, "rnd_end");
  endtask

  task automatic test_reset_mid_run();
    int r[NS] = '{2, 3, 4, 5};
    ap_start = 1'b1;
    scalar_in = rnd_sc();
    tick();
    ap_start = 1'b0;
    tick();
    checks++;
    if (slot_ap_start !== 4'hF) begin
      errors++;
      $display("FAIL midrst_pre slot_ap_start got=%b exp=1111",
               slot_ap_start);
    end
    tick();
    ap_rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst_async");
    #2 ap_rst_n = 1'b1;
    tick();
    exp_rc = '0;
    last_sc = '0;
    idle_check(1, "midrst_idle");
    do_run(r, r, rnd_sc(), 1'b0, 1'b0, "post_rst");
    idle_check(1, "post_rst_idle");
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_duplicate_done();
    test_min_run();
    test_back_to_back();
    test_random();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
